lsu_axi: RTL

- Parametrised load/store unit; successor of the current single-width write-back memory stage.
- Accepts one memory request per transaction from the execute stage over valid/ready.
- Drives an AXI4-Lite master port with independent AW/W handshakes and reports bus errors.
- Returns sign/zero-extended load data, or store completion, to write-back through a back-pressurable valid/ready output.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_lane_align.sv | 56 +++++
 rtl/lsu_axi.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module : lsu_pkg
// Desc   : Width/response encodings, FSM states and width legalisation
//          shared by the load/store unit.
// Rev    : 1.0
// ============================================================================
package lsu_pkg;

  localparam logic [2:0] WIDTH_B  = 3'b000;
  localparam logic [2:0] WIDTH_H  = 3'b001;
  localparam logic [2:0] WIDTH_W  = 3'b010;
  localparam logic [2:0] WIDTH_D  = 3'b011;
  localparam logic [2:0] WIDTH_BU = 3'b100;
  localparam logic [2:0] WIDTH_HU = 3'b101;
  localparam logic [2:0] WIDTH_WU = 3'b110;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    R    = 3'd2,
    WR   = 3'd3,
    B    = 3'd4,
    RESP = 3'd5
  } lsu_state_e;

  // Doubleword-class encodings have no meaning on a 32-bit bus; they collapse to a plain word.
  function automatic logic [2:0] legal_width(input logic [2:0] width, input int data_w);
    if (data_w == 32 && (width[1:0] == 2'b11 || width == WIDTH_WU)) return WIDTH_W;
    return width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module : lsu_lane_align
// Desc   : Byte-lane steering: store strobe/data shift and load lane
//          extraction with sign or zero extension.
// Rev    : 1.0
// ============================================================================
module lsu_lane_align #(
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8,
  parameter int OFF_W  = $clog2(STRB_W)
) (
  input  logic [OFF_W-1:0]  off,
  input  logic [2:0]        width,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [DATA_W-1:0] rdata_in,
  output logic [STRB_W-1:0] wstrb,
  output logic [DATA_W-1:0] wdata_out,
  output logic [DATA_W-1:0] rdata_out
);

  logic [3:0]        w_nbytes;
  logic [7:0]        w_base_mask;
  logic [15:0]       w_strb_wide;
  logic [OFF_W-1:0]  w_align_mask;
  logic              w_misaligned;
  logic [7:0]        w_lsh;
  logic [DATA_W-1:0] w_lane;
  logic [DATA_W-1:0] w_left;
  logic [DATA_W-1:0] w_sext;

  assign w_nbytes    = 4'd1 << width[1:0];
  assign w_base_mask = 8'((16'd1 << w_nbytes) - 16'd1);
  assign w_strb_wide = {8'd0, w_base_mask} << off;
  assign wstrb       = w_strb_wide[STRB_W-1:0];
  assign wdata_out   = wdata_in << {off, 3'b000};

  // Loads that are not naturally aligned return zero rather than a torn lane.
  assign w_align_mask = OFF_W'(w_nbytes - 4'd1);
  assign w_misaligned = |(off & w_align_mask);

  // Park the selected lane at the top, then shift back down to extend.
  assign w_lane = rdata_in >> {off, 3'b000};
  assign w_lsh  = 8'(DATA_W) - 8'({w_nbytes, 3'b000});
  assign w_left = w_lane << w_lsh;
  assign w_sext = $signed(w_left) >>> w_lsh;

  always_comb begin
    rdata_out = '0;
    if (!w_misaligned) begin
      rdata_out = width[2] ? (w_left >> w_lsh) : w_sext;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lsu_axi.sv
`default_nettype none
// ============================================================================
// Module : lsu_axi
// Desc   : Load/store unit with AXI4-Lite master port. Optional alignment
//          check on accept is built with LSU_MISALIGN_CHK_EN.
// Rev    : 1.0
// ============================================================================
module lsu_axi
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wen,
  input  logic [2:0]        in_width,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rdata,
  output logic              out_err,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  localparam int c_off_w = $clog2(STRB_W);

  lsu_state_e         r_state;
  lsu_state_e         w_state_nxt;
  logic [ADDR_W-1:0]  r_addr;
  logic [2:0]         r_width;
  logic               r_aw_done;
  logic               r_w_done;
  logic [2:0]         w_width_in;
  logic [2:0]         w_width;
  logic [c_off_w-1:0] w_off;
  logic               w_accept;
  logic               w_misalign;
  logic [STRB_W-1:0]  w_wstrb;
  logic [DATA_W-1:0]  w_wdata;
  logic [DATA_W-1:0]  w_rdata_ext;

  assign w_width_in = legal_width(in_width, DATA_W);
  assign w_accept   = in_valid && in_ready;
  assign araddr     = r_addr;
  assign awaddr     = r_addr;

  // One aligner serves the incoming request in IDLE and the latched one afterwards.
  assign w_off   = (r_state == IDLE) ? in_addr[c_off_w-1:0] : r_addr[c_off_w-1:0];
  assign w_width = (r_state == IDLE) ? w_width_in : r_width;

`ifdef LSU_MISALIGN_CHK_EN
  logic [3:0] w_nbytes_in;
  assign w_nbytes_in = 4'd1 << w_width_in[1:0];
  assign w_misalign  = |(in_addr[c_off_w-1:0] & c_off_w'(w_nbytes_in - 4'd1));
`else
  assign w_misalign  = 1'b0;
`endif

  lsu_lane_align #(
    .DATA_W (DATA_W),
    .STRB_W (STRB_W)
  ) u_lane_align (
    .off       (w_off),
    .width     (w_width),
    .wdata_in  (in_wdata),
    .rdata_in  (rdata),
    .wstrb     (w_wstrb),
    .wdata_out (w_wdata),
    .rdata_out (w_rdata_ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    arvalid     = 1'b0;
    rready      = 1'b0;
    awvalid     = 1'b0;
    wvalid      = 1'b0;
    bready      = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = w_misalign ? RESP : (in_wen ? WR : AR);
      end
      AR: begin
        arvalid = 1'b1;
        if (arready) w_state_nxt = R;
      end
      R: begin
        rready = 1'b1;
        if (rvalid) w_state_nxt = RESP;
      end
      WR: begin
        awvalid = !r_aw_done;
        wvalid  = !r_w_done;
        if ((r_aw_done || awready) && (r_w_done || wready)) w_state_nxt = B;
      end
      B: begin
        bready = 1'b1;
        if (bvalid) w_state_nxt = RESP;
      end
      RESP: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr    <= '0;
      r_width   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      wdata     <= '0;
      wstrb     <= '0;
      out_rdata <= '0;
      out_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr    <= in_addr;
        r_width   <= w_width_in;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        wdata     <= w_wdata;
        wstrb     <= w_wstrb;
        out_rdata <= '0;
        out_err   <= w_misalign;
      end
      if (awvalid && awready) r_aw_done <= 1'b1;
      if (wvalid && wready)   r_w_done  <= 1'b1;
      if (rready && rvalid) begin
        out_err   <= (rresp != RESP_OKAY);
        out_rdata <= (rresp == RESP_OKAY) ? w_rdata_ext : '0;
      end
      if (bready && bvalid) begin
        out_err   <= (bresp != RESP_OKAY);
        out_rdata <= '0;
      end
      if (out_valid && out_ready) begin
        out_err   <= 1'b0;
        out_rdata <= '0;
      end
    end
  end

endmodule
`default_nettype wire
